change_trace_logger: RTL and testbench
======================================

CHANGE_TRACE_LOGGER -- requirements
Module: change_trace_logger

Interface
REQ-001 Parameter: TS_W, default 16, timestamp counter width in bits (4..32).
REQ-002 Parameter: DEPTH, default 8, record buffer depth in entries (power of 2, 2..64).
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: en  input  1  capture enable; 0 suppresses new records.
REQ-006 Port: a, b, c  input  1 each  monitored signals.
REQ-007 Port: out_ready  input  1  consumer accepts the head record.
REQ-008 Port: ovf_clr  input  1  clears the sticky overflow flag.
REQ-009 Port: out_valid  output  1  the head record is available.
REQ-010 Port: out_ts  output  TS_W  timestamp of the head record.
REQ-011 Port: out_abc  output  3  {a,b,c} of the head record.
REQ-012 Port: level  output  clog2(DEPTH)+1  count of stored records.
REQ-013 Port: ovf  output  1  sticky flag; at least one record was dropped.
REQ-014 Port: drop_cnt  output  8  count of dropped records (see Configuration).

Function
REQ-015 Timestamp counter: free-running; +1 every cycle; wraps from 2^TS_W-1 to 0.
REQ-016 Register prev holds {a,b,c} sampled at every edge, regardless of en.
REQ-017 Change condition: en=1 and {a,b,c} != prev in the current cycle.
REQ-018 On a change, the edge writes one record {current counter value, current {a,b,c}} to the buffer.
REQ-019 Changes on several bits in the same cycle produce exactly one record.
REQ-020 Buffer: FIFO order, DEPTH entries; out_valid = (level != 0); out_ts/out_abc present the oldest record.
REQ-021 Handshake: a pop occurs on an edge where out_valid=1 and out_ready=1; out_ready with out_valid=0 has no effect.
REQ-022 Latency: a change sampled at edge N makes the record visible with out_valid=1 after edge N (one cycle) when the buffer was empty.
REQ-023 Outputs stay stable while out_valid=1 and out_ready=0.
REQ-024 Push while full without a simultaneous pop: record dropped, buffer unchanged, ovf set to 1.
REQ-025 Push and pop on the same edge while full: both take effect; no drop; level stays at DEPTH.
REQ-026 Push and pop on the same edge at any other level: level unchanged.
REQ-027 Pointers wrap modulo DEPTH.
REQ-028 ovf_clr=1 clears ovf on that edge; a drop on the same edge wins and leaves ovf=1.
REQ-029 en deasserted mid-stream: stored records remain poppable; no new records are written.

Reset
REQ-030 rst=1 on an edge sets counter=0, prev=3'b000, level=0, pointers=0, ovf=0, drop_cnt=0, and out_valid=0.
REQ-031 Reset overrides push, pop, and ovf_clr on the same edge; in-flight records are discarded.
REQ-032 out_ts and out_abc are 0 after reset until the first record is written.
REQ-033 On the first cycle after reset, an input value != 3'b000 is a change and is recorded.

Configuration
REQ-034 Macro TRACE_DROP_CNT_EN, when defined, enables an 8-bit drop counter.
REQ-035 The drop counter increments on each dropped record, saturates at 255, and clears on ovf_clr (a drop on the same edge leaves it at 1).
REQ-036 Without TRACE_DROP_CNT_EN, drop_cnt is tied to 0 and no counter logic exists; all other behaviour is identical.

Verification
REQ-037 Reset, then hold a=b=c=0 with en=1 for 20 cycles -> out_valid=0 and level=0 throughout.
REQ-038 From reset, set {a,b}=01 and c=1 at counter=5, with out_ready=1 -> one record, ts=5 and abc=3'b011, out_valid high for exactly one cycle.
REQ-039 Toggle a every cycle for 10 cycles with out_ready=0 and DEPTH=8 -> level=8, ovf=1, drop_cnt=2 (macro defined) or 0 (not defined); drain yields 8 records in order.
REQ-040 Buffer full with a change and out_ready=1 on the same cycle -> no drop, level stays 8, ovf unchanged.
REQ-041 TS_W=4, a change at counter=15 then at the next cycle -> records carry ts=15 then ts=0.
REQ-042 Assert rst with 3 records pending -> out_valid=0 and level=0 on the next cycle, ovf=0, and no stale records are emitted after reset.

Source files
------------

// File: rtl/change_trace_logger.sv
// change_trace_logger
//   Watches three single-bit signals. Each cycle where capture is enabled and
//   {a,b,c} differs from the value sampled on the previous edge, it stores one
//   record {timestamp, {a,b,c}} in a FIFO. The consumer drains the FIFO with a
//   valid/ready handshake. When a record arrives while the FIFO is full and no
//   pop happens on the same edge, that record is dropped and a sticky overflow
//   flag is set.
//
// Optional feature: define TRACE_DROP_CNT_EN to build an 8-bit saturating
//   counter of dropped records. Without it, drop_cnt is tied to zero.
//
// Parameters
//   TS_W       timestamp counter width (4..32)
//   DEPTH      record buffer depth (power of 2, 2..64)
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         capture enable
//   a, b, c    monitored signals
//   out_ready  consumer accepts the head record
//   ovf_clr    clears ovf (and drop_cnt)
//   out_valid  a head record is present
//   out_ts     timestamp of the head record (0 while the buffer is empty)
//   out_abc    {a,b,c} of the head record (0 while the buffer is empty)
//   level      number of stored records
//   ovf        sticky flag: at least one record was dropped
//   drop_cnt   number of dropped records (0 unless TRACE_DROP_CNT_EN)
module change_trace_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     a,
  input  logic                     b,
  input  logic                     c,
  input  logic                     out_ready,
  input  logic                     ovf_clr,
  output logic                     out_valid,
  output logic [TS_W-1:0]          out_ts,
  output logic [2:0]               out_abc,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = TS_W + 3;

  logic [TS_W-1:0] ts_cnt;
  logic [2:0]      prev;
  logic [2:0]      abc;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   count;
  logic [RW-1:0]   mem [DEPTH];
  logic [RW-1:0]   head;

  logic change;
  logic full;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    abc    = {a, b, c};
    change = en && (abc != prev);
    full   = (count == LW'(DEPTH));
    pop    = out_valid && out_ready;
    // When the buffer is full, a simultaneous pop frees the slot that the
    // write pointer already points at, so the push can still be accepted.
    push   = change && (!full || pop);
    drop   = change && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt <= '0;
      prev   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      prev   <= abc;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  // Record storage needs no reset: the outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= {ts_cnt, abc};
  end

  always_comb begin
    head      = mem[rd_ptr];
    out_valid = (count != '0);
    level     = count;
    out_ts    = out_valid ? head[RW-1:3] : '0;
    out_abc   = out_valid ? head[2:0]    : '0;
  end

`ifdef TRACE_DROP_CNT_EN
  logic [7:0] dcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt <= '0;
    end else if (drop) begin
      // A clear on the same edge as a drop restarts the count at that drop.
      if (ovf_clr)            dcnt <= 8'd1;
      else if (dcnt != '1)    dcnt <= dcnt + 8'd1;
    end else if (ovf_clr) begin
      dcnt <= '0;
    end
  end

  assign drop_cnt = dcnt;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_change_trace_logger.sv
// Testbench for change_trace_logger. Two instances share all inputs: one
// with a 16-bit timestamp and one with a 4-bit timestamp (wrap behaviour).
// A queue-based reference model is compared against both on every cycle,
// and directed scenarios add literal expectations.
module tb_change_trace_logger;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, en = 1'b0, a = 1'b0, b = 1'b0, c = 1'b0;
  logic out_ready = 1'b0, ovf_clr = 1'b0;

  logic        out_valid, ovf;
  logic [15:0] out_ts;
  logic [2:0]  out_abc;
  logic [3:0]  level;
  logic [7:0]  drop_cnt;

  logic        v4, ovf4;
  logic [3:0]  ts4;
  logic [2:0]  abc4;
  logic [3:0]  level4;
  logic [7:0]  dcnt4;

  change_trace_logger #(.TS_W(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c),
    .out_ready(out_ready), .ovf_clr(ovf_clr),
    .out_valid(out_valid), .out_ts(out_ts), .out_abc(out_abc),
    .level(level), .ovf(ovf), .drop_cnt(drop_cnt)
  );

  change_trace_logger #(.TS_W(4), .DEPTH(DEPTH)) dut4 (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c),
    .out_ready(out_ready), .ovf_clr(ovf_clr),
    .out_valid(v4), .out_ts(ts4), .out_abc(abc4),
    .level(level4), .ovf(ovf4), .drop_cnt(dcnt4)
  );

`ifdef TRACE_DROP_CNT_EN
  localparam int DCNT_ON = 1;
`else
  localparam int DCNT_ON = 0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Reference model: records hold the absolute cycle index since reset.
  typedef struct {
    int unsigned ts;
    logic [2:0]  abc;
  } rec_t;

  rec_t        mq[$];
  int unsigned m_cnt = 0;
  logic [2:0]  m_prev = 3'b000;
  bit          m_ovf = 1'b0;
  int          m_drop = 0;
  bit          m_written = 1'b0;
  bit          chk_on = 1'b0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_cnt = 0; m_prev = 3'b000; m_ovf = 1'b0; m_drop = 0; m_written = 1'b0;
    end else begin
      bit         pop, chg, drp;
      logic [2:0] cur;
      cur = {a, b, c};
      pop = (mq.size() != 0) && out_ready;
      chg = en && (cur != m_prev);
      drp = chg && (mq.size() == DEPTH) && !pop;
      if (pop) void'(mq.pop_front());
      if (chg && !drp) begin
        mq.push_back('{m_cnt, cur});
        m_written = 1'b1;
      end
      if (drp) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (DCNT_ON != 0) begin
        if (drp) m_drop = ovf_clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
        else if (ovf_clr) m_drop = 0;
      end
      m_prev = cur;
      m_cnt++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      check("valid",     out_valid, mq.size() != 0);
      check("level",     level,     mq.size());
      check("ovf",       ovf,       m_ovf);
      check("drop_cnt",  drop_cnt,  m_drop);
      check("valid4",    v4,        mq.size() != 0);
      check("level4",    level4,    mq.size());
      check("ovf4",      ovf4,      m_ovf);
      check("drop_cnt4", dcnt4,     m_drop);
      if (mq.size() != 0) begin
        check("head_ts",   out_ts,  16'(mq[0].ts));
        check("head_abc",  out_abc, mq[0].abc);
        check("head_ts4",  ts4,     4'(mq[0].ts));
        check("head_abc4", abc4,    mq[0].abc);
      end else if (!m_written) begin
        check("rst_ts",  out_ts,  0);
        check("rst_abc", out_abc, 0);
        check("rst_ts4", ts4,     0);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; a = 1'b0; b = 1'b0; c = 1'b0;
    out_ready = 1'b0; ovf_clr = 1'b0;
    tick(2);
    chk_on = 1'b1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic       en;
    logic       rdy;
    logic [2:0] abc;
  } vec_t;

  vec_t vecs[8] = '{
    '{1'b1, 1'b0, 3'b111}, '{1'b1, 1'b0, 3'b111}, '{1'b1, 1'b1, 3'b010},
    '{1'b0, 1'b1, 3'b101}, '{1'b0, 1'b1, 3'b101}, '{1'b1, 1'b0, 3'b000},
    '{1'b1, 1'b1, 3'b110}, '{1'b1, 1'b1, 3'b110}
  };

  initial begin
    int k;

    // Idle: constant zero inputs never produce a record.
    do_reset();
    repeat (20) begin
      tick(1);
      check("idle_valid", out_valid, 0);
      check("idle_level", level, 0);
    end

    // Single record sampled at counter 5, popped immediately.
    do_reset();
    tick(5);
    a = 1'b0; b = 1'b1; c = 1'b1; out_ready = 1'b1;
    tick(1);
    check("single_valid", out_valid, 1);
    check("single_ts",    out_ts,    5);
    check("single_abc",   out_abc,   3);
    tick(1);
    check("single_gone",  out_valid, 0);
    check("single_level", level,     0);

    // Overflow: ten changes into an eight-entry buffer.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      a = ~a;
      tick(1);
    end
    check("ovf_level",    level,    8);
    check("ovf_flag",     ovf,      1);
    check("ovf_dropcnt",  drop_cnt, 2 * DCNT_ON);
    check("ovf_head_ts",  out_ts,   0);
    check("ovf_head_abc", out_abc,  3'b100);

    // Full buffer, change and pop on the same edge: no drop.
    a = 1'b1; out_ready = 1'b1;
    tick(1);
    check("fullpp_level",   level,    8);
    check("fullpp_ovf",     ovf,      1);
    check("fullpp_dropcnt", drop_cnt, 2 * DCNT_ON);
    check("fullpp_head_ts", out_ts,   1);
    check("fullpp_head_abc", out_abc, 0);

    k = 0;
    while (out_valid && k < 20) begin
      tick(1);
      k++;
    end
    check("drain_empty", out_valid, 0);
    check("drain_count", k, 8);

    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("clr_ovf",     ovf,      0);
    check("clr_dropcnt", drop_cnt, 0);

    // Drop and clear on the same edge: the drop wins.
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      a = ~a;
      ovf_clr = (i == 8);
      tick(1);
    end
    ovf_clr = 1'b0;
    check("dropclr_ovf",     ovf,      1);
    check("dropclr_dropcnt", drop_cnt, DCNT_ON);
    check("dropclr_level",   level,    8);

    // Multi-bit changes, enable gating, mixed handshakes.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      en = vecs[i].en; out_ready = vecs[i].rdy;
      {a, b, c} = vecs[i].abc;
      tick(1);
      if (i == 0) check("multibit_one_rec", level, 1);
    end
    en = 1'b1; out_ready = 1'b1;
    tick(6);
    check("table_drained", out_valid, 0);

    // 4-bit timestamp wrap: records at counter 15 and 0.
    do_reset();
    tick(15);
    c = 1'b1;
    tick(1);
    c = 1'b0;
    tick(1);
    check("wrap_level",  level4, 2);
    check("wrap_ts_15",  ts4,    15);
    out_ready = 1'b1;
    tick(1);
    check("wrap_ts_0",   ts4,    0);
    check("wrap_ts_16",  out_ts, 16);
    check("wrap_level1", level4, 1);

    // Reset with records pending discards them.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      b = ~b;
      tick(1);
    end
    check("pend_level", level, 3);
    rst = 1'b1;
    tick(1);
    check("rst_valid", out_valid, 0);
    check("rst_level", level,     0);
    check("rst_ovf",   ovf,       0);
    a = 1'b0; b = 1'b0; c = 1'b0; rst = 1'b0; out_ready = 1'b1;
    repeat (5) begin
      tick(1);
      check("rst_no_stale", out_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
